// File: rtl/alu_issue_if.sv
// Handshake and writeback bundle between the upstream fetch side, the
// alu_issue_stage and the ALU/writeback side.
interface alu_issue_if #(
  parameter int XLEN = 32
);
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic            alu_valid;
  logic            alu_ready;
  logic [XLEN-1:0] alu_op1;
  logic [XLEN-1:0] alu_op2;
  logic [2:0]      ALU_op;
  logic [6:0]      ALU_op_ext;
  logic [4:0]      alu_rd;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            illegal;

  // Environment side: presents instructions, consumes ALU ops, returns results.
  modport master (
    output instr_valid, instr, alu_ready, wb_en, wb_rd, wb_data,
    input  instr_ready, alu_valid, alu_op1, alu_op2, ALU_op, ALU_op_ext, alu_rd, illegal
  );

  modport slave (
    input  instr_valid, instr, alu_ready, wb_en, wb_rd, wb_data,
    output instr_ready, alu_valid, alu_op1, alu_op2, ALU_op, ALU_op_ext, alu_rd, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I OP/OP-IMM decode and operand issue with register file and busy scoreboard.
// Optional ISSUE_PERF_EN adds perf_issued / perf_stall counters.
module alu_issue_stage #(
  parameter int XLEN     = 32,
  parameter bit RF_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  alu_issue_if.slave  bus
`ifdef ISSUE_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_stall
`endif
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_ILLEGAL} fmt_e;

  logic [XLEN-1:0] rf [32];
  logic [31:0]     busy;

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic [6:0] funct7;
  fmt_e       fmt;

  assign opcode = bus.instr[6:0];
  assign rd     = bus.instr[11:7];
  assign funct3 = bus.instr[14:12];
  assign rs1    = bus.instr[19:15];
  assign rs2    = bus.instr[24:20];
  assign funct7 = bus.instr[31:25];

  always_comb begin
    fmt = FMT_ILLEGAL;
    case (opcode)
      OPC_OP:     fmt = FMT_R;
      OPC_OP_IMM: fmt = FMT_I;
      default:    fmt = FMT_ILLEGAL;
    endcase
  end

  // Writeback is only honoured out of reset; it both bypasses reads and frees the register.
  logic            wb_act;
  logic [31:0]     wb_clr;
  logic [31:0]     busy_eff;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign wb_act   = rst & bus.wb_en;
  assign wb_clr   = wb_act ? (32'd1 << bus.wb_rd) : 32'd0;
  assign busy_eff = busy & ~wb_clr;

  assign rs1_val = (rs1 == 5'd0)                   ? '0          :
                   (wb_act && (bus.wb_rd == rs1))  ? bus.wb_data : rf[rs1];
  assign rs2_val = (rs2 == 5'd0)                   ? '0          :
                   (wb_act && (bus.wb_rd == rs2))  ? bus.wb_data : rf[rs2];

  logic stall, accept, legal;

  assign legal           = (fmt != FMT_ILLEGAL);
  assign stall           = busy_eff[rs1] | ((fmt == FMT_R) & busy_eff[rs2]);
  assign bus.instr_ready = rst & ~stall & (~bus.alu_valid | bus.alu_ready);
  assign accept          = bus.instr_valid & bus.instr_ready;

  logic [XLEN-1:0] nxt_op2;
  logic [6:0]      nxt_ext;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    nxt_op2 = rs2_val;
    nxt_ext = funct7;
    if (fmt == FMT_I) begin
      if (funct3 == 3'd1 || funct3 == 3'd5) begin
        nxt_op2 = {{(XLEN-5){1'b0}}, bus.instr[24:20]};
        nxt_ext = funct7;
      end else begin
        nxt_op2 = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
        nxt_ext = '0;
      end
    end
  end

  // Set is OR-ed after the clear so a same-cycle set and clear leaves the register busy.
  logic [31:0] set_mask;
  assign set_mask = (accept && legal && (rd != 5'd0)) ? (32'd1 << rd) : 32'd0;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.alu_valid  <= 1'b0;
      bus.alu_op1    <= '0;
      bus.alu_op2    <= '0;
      bus.ALU_op     <= '0;
      bus.ALU_op_ext <= '0;
      bus.alu_rd     <= '0;
      bus.illegal    <= 1'b0;
      busy           <= '0;
    end else begin
      bus.illegal <= accept & ~legal;
      busy        <= (busy & ~wb_clr) | set_mask;
      if (accept && legal) begin
        bus.alu_valid  <= 1'b1;
        bus.alu_op1    <= rs1_val;
        bus.alu_op2    <= nxt_op2;
        bus.ALU_op     <= funct3;
        bus.ALU_op_ext <= nxt_ext;
        bus.alu_rd     <= rd;
      end else if (bus.alu_ready) begin
        bus.alu_valid <= 1'b0;
      end
    end
  end

  // NOTE: the register file only gets a reset branch when RF_RESET asks for it; otherwise it stays plain storage.
  generate
    if (RF_RESET) begin : g_rf_rst
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wb_act && (bus.wb_rd != 5'd0)) begin
          rf[bus.wb_rd] <= bus.wb_data;
        end
      end
    end else begin : g_rf_norst
      always_ff @(posedge clk) begin
        if (wb_act && (bus.wb_rd != 5'd0)) rf[bus.wb_rd] <= bus.wb_data;
      end
    end
  endgenerate

`ifdef ISSUE_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (accept && legal)            perf_issued <= perf_issued + 32'd1;
      if (bus.instr_valid && stall)   perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: expected ALU ops are queued at accept
// and popped when the stage presents them.
module tb_alu_issue_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_if #(.XLEN(32)) bus ();

`ifdef ISSUE_PERF_EN
  logic [31:0] perf_issued, perf_stall;
`endif

  alu_issue_stage #(.XLEN(32), .RF_RESET(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ISSUE_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  op;
    logic [6:0]  ext;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb_q[$];
  exp_t last;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   w;

  function automatic exp_t mk(input logic [31:0] op1, input logic [31:0] op2,
                              input logic [2:0] op, input logic [6:0] ext,
                              input logic [4:0] rd);
    exp_t e;
    e.op1 = op1; e.op2 = op2; e.op = op; e.ext = ext; e.rd = rd;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    bus.wb_en = 1'b1; bus.wb_rd = r; bus.wb_data = d;
    @(negedge clk);
    bus.wb_en = 1'b0;
  endtask

  // Present a word until accepted (bounded); returns the number of stalled cycles.
  task automatic issue(input logic [31:0] word, input bit is_legal, input exp_t e, output int waited);
    bit accepted;
    accepted = 1'b0;
    waited   = 0;
    bus.instr       = word;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      #1;
      if (bus.instr_ready) begin
        accepted = 1'b1;
        if (is_legal) sb_q.push_back(e);
      end else begin
        waited++;
      end
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    check("issue_accepted", 32'(accepted), 32'd1);
  endtask

  task automatic expect_out();
    exp_t e;
    check("alu_valid", 32'(bus.alu_valid), 32'd1);
    check("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e    = sb_q.pop_front();
      last = e;
      check("alu_op1",    bus.alu_op1,          e.op1);
      check("alu_op2",    bus.alu_op2,          e.op2);
      check("ALU_op",     32'(bus.ALU_op),      32'(e.op));
      check("ALU_op_ext", 32'(bus.ALU_op_ext),  32'(e.ext));
      check("alu_rd",     32'(bus.alu_rd),      32'(e.rd));
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, 32'(bus.alu_valid),  32'd0);
    check({tag, "_op1"},   bus.alu_op1,         32'd0);
    check({tag, "_op2"},   bus.alu_op2,         32'd0);
    check({tag, "_op"},    32'(bus.ALU_op),     32'd0);
    check({tag, "_ext"},   32'(bus.ALU_op_ext), 32'd0);
    check({tag, "_rd"},    32'(bus.alu_rd),     32'd0);
    check({tag, "_ill"},   32'(bus.illegal),    32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.instr_valid = 1'b0; bus.instr = '0; bus.alu_ready = 1'b1;
    bus.wb_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    repeat (3) @(negedge clk);

    // Reset state; ready must stay low while in reset even with a word presented
    check_cleared("reset");
    bus.instr = 32'h002081B3; bus.instr_valid = 1'b1;
    #1 check("ready_in_reset", 32'(bus.instr_ready), 32'd0);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    rst = 1'b1;

    // 1. Register setup then ADD x3,x1,x2
    wb(5'd1, 32'd10);
    wb(5'd2, 32'd20);
    issue(32'h002081B3, 1'b1, mk(32'd10, 32'd20, 3'd0, 7'h00, 5'd3), w);
    check("add_no_wait", w, 0);
    expect_out();

    // 2. SUB back-to-back, SRAI, ADDI with negative immediate
    issue(32'h402081B3, 1'b1, mk(32'd10, 32'd20, 3'd0, 7'h20, 5'd3), w);
    check("sub_back_to_back", w, 0);
    expect_out();
    issue(32'h4020D293, 1'b1, mk(32'd10, 32'd2, 3'd5, 7'h20, 5'd5), w);
    expect_out();
    issue(32'hFFF00213, 1'b1, mk(32'd0, 32'hFFFFFFFF, 3'd0, 7'h00, 5'd4), w);
    expect_out();

    // 3. RAW on x3 (busy since SUB) resolved by same-cycle writeback
    bus.instr = 32'h00118233; bus.instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("raw_stall_ready", 32'(bus.instr_ready), 32'd0);
      @(negedge clk);
    end
    check("raw_drain_valid", 32'(bus.alu_valid), 32'd0);
    bus.wb_en = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'd30;
    #1 check("raw_wb_ready", 32'(bus.instr_ready), 32'd1);
    sb_q.push_back(mk(32'd30, 32'd10, 3'd0, 7'h00, 5'd4));
    @(negedge clk);
    bus.instr_valid = 1'b0; bus.wb_en = 1'b0;
    expect_out();

    // 4. Backpressure: outputs hold for 5 cycles, then back-to-back accept
    @(negedge clk);
    bus.alu_ready = 1'b0;
    issue(32'h00208333, 1'b1, mk(32'd10, 32'd20, 3'd0, 7'h00, 5'd6), w);
    expect_out();
    bus.instr = 32'h402083B3; bus.instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ready",    32'(bus.instr_ready), 32'd0);
      check("bp_valid",    32'(bus.alu_valid),   32'd1);
      check("bp_op1",      bus.alu_op1,          last.op1);
      check("bp_op2",      bus.alu_op2,          last.op2);
      check("bp_rd",       32'(bus.alu_rd),      32'(last.rd));
      @(negedge clk);
    end
    bus.alu_ready = 1'b1;
    #1 check("bp_release_ready", 32'(bus.instr_ready), 32'd1);
    sb_q.push_back(mk(32'd10, 32'd20, 3'd0, 7'h20, 5'd7));
    @(negedge clk);
    bus.instr_valid = 1'b0;
    expect_out();

    // 5. Illegal JAL x8: single pulse, no op, x8 not marked busy
    issue(32'h0000046F, 1'b0, mk('0, '0, '0, '0, '0), w);
    check("ill_valid", 32'(bus.alu_valid), 32'd0);
    check("ill_pulse", 32'(bus.illegal),   32'd1);
    issue(32'h000404B3, 1'b1, mk(32'd0, 32'd0, 3'd0, 7'h00, 5'd9), w);
    check("ill_x8_not_busy", w, 0);
    check("ill_pulse_end", 32'(bus.illegal), 32'd0);
    expect_out();
    wb(5'd0, 32'hDEADBEEF);
    issue(32'h00000533, 1'b1, mk(32'd0, 32'd0, 3'd0, 7'h00, 5'd10), w);
    expect_out();

    // Write-first bypass: x1 written in the same cycle ADD x11 reads it
    bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'd55;
    issue(32'h002085B3, 1'b1, mk(32'd55, 32'd20, 3'd0, 7'h00, 5'd11), w);
    bus.wb_en = 1'b0;
    check("bypass_no_wait", w, 0);
    expect_out();

    // 6. Reset while an op is pending and x3 busy
    @(negedge clk);
    bus.alu_ready = 1'b0;
    issue(32'h002081B3, 1'b1, mk(32'd55, 32'd20, 3'd0, 7'h00, 5'd3), w);
    expect_out();
    @(negedge clk);
    check("pending_held", 32'(bus.alu_valid), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_cleared("midreset");
`ifdef ISSUE_PERF_EN
    check("perf_issued_rst", perf_issued, 32'd0);
    check("perf_stall_rst",  perf_stall,  32'd0);
`endif
    rst = 1'b1;
    bus.alu_ready = 1'b1;
    issue(32'h00118233, 1'b1, mk(32'd0, 32'd0, 3'd0, 7'h00, 5'd4), w);
    check("x3_not_busy_after_rst", w, 0);
    expect_out();
`ifdef ISSUE_PERF_EN
    check("perf_issued_one", perf_issued, 32'd1);
    check("perf_stall_zero", perf_stall,  32'd0);
`endif
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
